// File: rtl/data_pipe_sync_stage.sv
// Registered valid/ready pipeline stage with a two-entry skid buffer; side-band word travels with stream data.
// Optional simulation-only protocol checks are compiled when DATA_PIPE_PROTOCOL_CHECK_EN is defined.
module data_pipe_sync_stage #(
    parameter int DSIZE  = 32,
    parameter int IDSIZE = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DSIZE-1:0]  in_data,
    input  logic [IDSIZE-1:0] in_inf_data,
    input  logic              in_inf_valid,
    output logic              in_inf_ready,
    output logic [DSIZE-1:0]  out_data,
    output logic [IDSIZE-1:0] out_inf_data,
    output logic              out_inf_valid,
    input  logic              out_inf_ready
);

    // Handshake: a transfer happens on a rising clock edge where valid and ready are both 1.
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            state, state_next;
    logic              in_ready_q, out_valid_q;
    logic              in_fire, out_fire;
    logic [IDSIZE-1:0] main_data, main_data_next, skid_data, skid_data_next;
    logic [DSIZE-1:0]  main_side, main_side_next, skid_side, skid_side_next;

    assign in_fire  = in_inf_valid & in_ready_q;
    assign out_fire = out_valid_q & out_inf_ready;

    // State register; both handshake outputs are flops decoded from the next state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next != TWO);
            out_valid_q <= (state_next != EMPTY);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (in_fire) state_next = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_next = TWO;
                else if (!in_fire && out_fire) state_next = EMPTY;
            end
            TWO:     if (out_fire) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        main_data_next = main_data;
        main_side_next = main_side;
        skid_data_next = skid_data;
        skid_side_next = skid_side;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_data_next = in_inf_data;
                    main_side_next = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_next = in_inf_data;
                    main_side_next = in_data;
                end else if (in_fire) begin
                    skid_data_next = in_inf_data;
                    skid_side_next = in_data;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_data_next = skid_data;
                    main_side_next = skid_side;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_side <= '0;
            skid_data <= '0;
            skid_side <= '0;
        end else begin
            main_data <= main_data_next;
            main_side <= main_side_next;
            skid_data <= skid_data_next;
            skid_side <= skid_side_next;
        end
    end

    assign in_inf_ready  = in_ready_q;
    assign out_inf_valid = out_valid_q;
    assign out_inf_data  = main_data;
    assign out_data      = main_side;

`ifdef DATA_PIPE_PROTOCOL_CHECK_EN
    // An offer that was stalled at the previous edge must be held unchanged.
    logic              prev_stalled;
    logic [IDSIZE-1:0] prev_inf_data;
    logic [DSIZE-1:0]  prev_side;

    always @(posedge clock) begin
        if (rst_n) begin
            if ($isunknown(in_inf_valid) || $isunknown(out_inf_ready))
                $error("data_pipe_sync_stage: X/Z on in_inf_valid or out_inf_ready");
            if (prev_stalled && (!in_inf_valid || in_inf_data != prev_inf_data || in_data != prev_side))
                $error("data_pipe_sync_stage: stalled input dropped or changed");
            prev_stalled  <= in_inf_valid && !in_ready_q;
            prev_inf_data <= in_inf_data;
            prev_side     <= in_data;
        end else begin
            prev_stalled <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_data_pipe_sync_stage.sv
// Self-checking bench for data_pipe_sync_stage: directed vector table, streaming, reset, random scoreboard, 4-stage chain.
module tb_data_pipe_sync_stage;
    localparam int DW = 16;
    localparam int IW = 8;
    localparam int NWORDS = 10000;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_inf_data = '0;
    logic          in_inf_valid = 1'b0;
    logic          in_inf_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_inf_data;
    logic          out_inf_valid;
    logic          out_inf_ready = 1'b0;

    // 4-stage chain
    logic [DW-1:0] ch_side [0:4];
    logic [IW-1:0] ch_data [0:4];
    logic          ch_valid [0:4];
    logic          ch_ready [0:4];
    logic [DW-1:0] ch_in_side = '0;
    logic [IW-1:0] ch_in_data = '0;
    logic          ch_in_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_pipe_sync_stage #(.DSIZE(DW), .IDSIZE(IW)) dut (
        .clock(clock), .rst_n(rst_n),
        .in_data(in_data), .in_inf_data(in_inf_data),
        .in_inf_valid(in_inf_valid), .in_inf_ready(in_inf_ready),
        .out_data(out_data), .out_inf_data(out_inf_data),
        .out_inf_valid(out_inf_valid), .out_inf_ready(out_inf_ready)
    );

    assign ch_side[0]  = ch_in_side;
    assign ch_data[0]  = ch_in_data;
    assign ch_valid[0] = ch_in_valid;
    assign ch_ready[4] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_chain
        data_pipe_sync_stage #(.DSIZE(DW), .IDSIZE(IW)) stage (
            .clock(clock), .rst_n(rst_n),
            .in_data(ch_side[g]), .in_inf_data(ch_data[g]),
            .in_inf_valid(ch_valid[g]), .in_inf_ready(ch_ready[g]),
            .out_data(ch_side[g+1]), .out_inf_data(ch_data[g+1]),
            .out_inf_valid(ch_valid[g+1]), .out_inf_ready(ch_ready[g+1])
        );
    end

    typedef struct {
        logic          v;
        logic [IW-1:0] d;
        logic [DW-1:0] s;
        logic          ordy;
        logic          exp_v;
        logic          exp_rdy;
        logic [IW-1:0] exp_d;
        logic [DW-1:0] exp_s;
    } vec_t;

    vec_t vecs[14];
    logic [IW+DW-1:0] exp_q[$];

    function automatic vec_t mk(logic v, logic [IW-1:0] d, logic [DW-1:0] s, logic ordy,
                                logic ev, logic er, logic [IW-1:0] ed, logic [DW-1:0] es);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.ordy = ordy;
        r.exp_v = ev; r.exp_rdy = er; r.exp_d = ed; r.exp_s = es;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic er,
                              input logic [IW-1:0] ed, input logic [DW-1:0] es);
        check({name, ".valid"}, 32'(out_inf_valid), 32'(ev));
        check({name, ".ready"}, 32'(in_inf_ready), 32'(er));
        check({name, ".data"}, 32'(out_inf_data), 32'(ed));
        check({name, ".side"}, 32'(out_data), 32'(es));
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] d, input logic [DW-1:0] s, input logic ordy);
        in_inf_valid  = v;
        in_inf_data   = d;
        in_data       = s;
        out_inf_ready = ordy;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: each row is applied for one edge, outputs checked just after it.
        vecs[0]  = mk(0, 8'h00, 16'h0000, 1,  0, 1, 8'h00, 16'h0000);
        vecs[1]  = mk(1, 8'hA5, 16'h003C, 1,  1, 1, 8'hA5, 16'h003C);
        vecs[2]  = mk(0, 8'h00, 16'h0000, 1,  0, 1, 8'hA5, 16'h003C);
        vecs[3]  = mk(1, 8'h01, 16'h00FE, 0,  1, 1, 8'h01, 16'h00FE);
        vecs[4]  = mk(1, 8'h02, 16'h00FD, 0,  1, 0, 8'h01, 16'h00FE);
        vecs[5]  = mk(1, 8'h03, 16'h00FC, 0,  1, 0, 8'h01, 16'h00FE);
        vecs[6]  = mk(1, 8'h03, 16'h00FC, 0,  1, 0, 8'h01, 16'h00FE);
        vecs[7]  = mk(1, 8'h03, 16'h00FC, 1,  1, 1, 8'h02, 16'h00FD);
        vecs[8]  = mk(1, 8'h03, 16'h00FC, 1,  1, 1, 8'h03, 16'h00FC);
        vecs[9]  = mk(0, 8'h00, 16'h0000, 1,  0, 1, 8'h03, 16'h00FC);
        vecs[10] = mk(1, 8'h04, 16'h00FB, 0,  1, 1, 8'h04, 16'h00FB);
        vecs[11] = mk(0, 8'h00, 16'h0000, 0,  1, 1, 8'h04, 16'h00FB);
        vecs[12] = mk(1, 8'h05, 16'h00FA, 1,  1, 1, 8'h05, 16'h00FA);
        vecs[13] = mk(0, 8'h00, 16'h0000, 1,  0, 1, 8'h05, 16'h00FA);

        // Power-on reset
        drive(1, 8'h77, 16'h1234, 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outs("por", 0, 0, 8'h00, 16'h0000);
        drive(0, 8'h00, 16'h0000, 1);
        rst_n = 1'b1;
        #1;
        check("por_release.ready_before_edge", 32'(in_inf_ready), 32'd0);
        @(posedge clock); #1;
        check("por_release.ready_after_edge", 32'(in_inf_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].ordy);
            @(posedge clock); #1;
            check_outs($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_rdy, vecs[i].exp_d, vecs[i].exp_s);
        end

        // Streaming 0..15 with out_inf_ready held high
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            drive(1, IW'(i), DW'(16'hFFFF ^ 16'(i)), 1);
            @(posedge clock); #1;
            check_outs($sformatf("stream%0d", i), 1, 1, IW'(i), DW'(16'hFFFF ^ 16'(i)));
        end
        @(negedge clock);
        drive(0, 8'h00, 16'h0000, 1);
        @(posedge clock); #1;
        check("stream_end.valid", 32'(out_inf_valid), 32'd0);

        // Fill to TWO, then reset mid-operation
        @(negedge clock);
        drive(1, 8'h11, 16'h0111, 0);
        @(posedge clock);
        @(negedge clock);
        drive(1, 8'h22, 16'h0222, 0);
        @(posedge clock); #1;
        check_outs("fill_two", 1, 0, 8'h11, 16'h0111);
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        check_outs("mid_reset_async", 0, 0, 8'h00, 16'h0000);
        @(posedge clock); #1;
        check_outs("mid_reset_held", 0, 0, 8'h00, 16'h0000);
        @(negedge clock);
        drive(0, 8'h00, 16'h0000, 1);
        rst_n = 1'b1;
        #1;
        check("mid_release.ready_before_edge", 32'(in_inf_ready), 32'd0);
        @(posedge clock); #1;
        check_outs("mid_release", 0, 1, 8'h00, 16'h0000);

        // Random traffic against an in-order scoreboard
        begin
            int sent = 0, recv = 0, cycles = 0;
            logic hold = 1'b0, prev_stall = 1'b0;
            logic [IW-1:0] prev_d;
            logic [DW-1:0] prev_s;
            logic ifire, ofire;
            logic [IW+DW-1:0] exp;
            while (recv < NWORDS && cycles < 60000) begin
                @(negedge clock);
                cycles++;
                if (!hold) begin
                    if (sent < NWORDS && $urandom_range(0, 1) == 1)
                        drive(1, IW'($urandom), DW'($urandom), 1'b0);
                    else
                        in_inf_valid = 1'b0;
                end
                out_inf_ready = 1'($urandom_range(0, 1));
                #1;
                if (prev_stall) begin
                    check("rand_stable.data", 32'(out_inf_data), 32'(prev_d));
                    check("rand_stable.side", 32'(out_data), 32'(prev_s));
                end
                ifire = in_inf_valid & in_inf_ready;
                ofire = out_inf_valid & out_inf_ready;
                if (ofire) begin
                    if (exp_q.size() == 0) begin
                        check("rand_unexpected_output", 32'(out_inf_valid), 32'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check("rand_word", 32'({out_inf_data, out_data}), 32'(exp));
                    end
                    recv++;
                end
                if (ifire) begin
                    exp_q.push_back({in_inf_data, in_data});
                    sent++;
                end
                hold = in_inf_valid & ~ifire;
                prev_stall = out_inf_valid & ~out_inf_ready;
                prev_d = out_inf_data;
                prev_s = out_data;
            end
            check("rand_received", 32'(recv), 32'(NWORDS));
            check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
            @(negedge clock);
            drive(0, 8'h00, 16'h0000, 1);
            repeat (3) @(posedge clock);
            #1;
            check("rand_drained.valid", 32'(out_inf_valid), 32'd0);
        end

        // Four-stage chain: a word offered in cycle c shows up at the chain output in cycle c+4
        begin
            logic pat [0:7];
            pat = '{1, 1, 0, 1, 1, 1, 0, 0};
            for (int c = 0; c < 13; c++) begin
                @(negedge clock);
                #1;
                check($sformatf("chain_ready%0d", c), 32'(ch_ready[0]), 32'd1);
                if (c >= 4) begin
                    check($sformatf("chain_valid%0d", c), 32'(ch_valid[4]),
                          32'((c - 4 < 8) ? pat[c-4] : 1'b0));
                    if (c - 4 < 8 && pat[c-4]) begin
                        check($sformatf("chain_data%0d", c), 32'(ch_data[4]), 32'(8'h10 + (c - 4)));
                        check($sformatf("chain_side%0d", c), 32'(ch_side[4]), 32'(16'hA000 + (c - 4)));
                    end
                end
                ch_in_valid = (c < 8) ? pat[c] : 1'b0;
                ch_in_data  = IW'(8'h10 + c);
                ch_in_side  = DW'(16'hA000 + c);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_pipe_sync_stage.md
Name: data_pipe_sync_stage

Overview:
- Single-clock, one-deep registered pipeline stage on a valid/ready stream, fully registered in both directions via a two-entry skid buffer.
- Carries a side-band word alongside the stream data; both travel as one transfer.
- Cascaded N times to build an N-cycle-latency seam that keeps side-band and stream data aligned.

Parameters:
- DSIZE, 32, width of side-band word in_data/out_data.
- IDSIZE, 32, width of stream data in_inf_data/out_inf_data.

Ports:
- clock  input  1  stage clock.
- rst_n  input  1  reset.
- in_data  input  DSIZE  side-band word; sampled with the input transfer.
- in_inf_data  input  IDSIZE  upstream stream data.
- in_inf_valid  input  1  upstream valid.
- in_inf_ready  output  1  upstream ready; driven directly from a flop.
- out_data  output  DSIZE  side-band word paired with the current output transfer.
- out_inf_data  output  IDSIZE  downstream stream data.
- out_inf_valid  output  1  downstream valid; driven directly from a flop.
- out_inf_ready  input  1  downstream ready.

Interface (already decided): one clock; reset is asynchronous and active-low (ports clock, rst_n).

Behaviour:
- Transfer definitions:
  - in_fire = in_inf_valid & in_inf_ready.
  - out_fire = out_inf_valid & out_inf_ready.
  - Both are evaluated on the rising edge of clock.
- Storage: main register {data, side} drives the outputs; skid register {data, side} holds one extra entry. Data and side-band always move together.
- States: EMPTY, ONE, TWO.
  - out_inf_valid = (state != EMPTY).
  - in_inf_ready = (state != TWO), held in a flop.
- Transitions:
  - EMPTY: in_fire -> ONE, main <= input; otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> ONE, main <= input.
  - ONE, in_fire & !out_fire -> TWO, skid <= input.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> stay ONE.
  - TWO: no input accepted; out_fire -> ONE, main <= skid; otherwise stay TWO.
- Ordering: strict FIFO, no loss, no duplication.
- Latency: a word accepted at edge N is on the outputs, with valid=1, after edge N, provided the stage was EMPTY, or ONE with out_fire at edge N.
- Throughput: with out_inf_ready held 1, one transfer per cycle and in_inf_ready stays 1.
- Backpressure: with out_inf_ready=0, two words are accepted, then in_inf_ready=0 from the edge after the second acceptance.
- Stability: while out_inf_valid=1 and out_inf_ready=0, out_inf_data and out_data are held constant.
- Reset (rst_n low, async), and reset mid-operation:
  - state=EMPTY; out_inf_valid=0; in_inf_ready=0.
  - Main and skid registers cleared to 0, so out_data=0 and out_inf_data=0.
  - Any buffered data is discarded.
  - in_inf_ready rises to 1 on the first clock edge with rst_n high.
- Input while reset is asserted is ignored.
- in_inf_valid is not required to stay high if the stage is not ready; an input offered when in_inf_ready=0 is simply not taken.

Optional Feature:
- Macro: DATA_PIPE_PROTOCOL_CHECK_EN.
- Defined: simulation-only checks, active while rst_n high, that issue $error when:
  - upstream drops in_inf_valid, or changes in_inf_data/in_data, while in_inf_valid=1 and in_inf_ready=0;
  - any X/Z appears on in_inf_valid or out_inf_ready.
- Undefined: no checking logic compiled; RTL function identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with the stage in state TWO -> outputs immediately out_inf_valid=0, in_inf_ready=0, out_data=0, out_inf_data=0; first edge after release -> in_inf_ready=1.
- Single transfer: in_inf_data=0xA5, in_data=0x3C, one-cycle valid, out_inf_ready=1 -> next cycle out_inf_valid=1, out_inf_data=0xA5, out_data=0x3C; the cycle after that, valid=0.
- Streaming: send 0..15 back-to-back with in_data=~value, out_inf_ready=1 -> 16 consecutive output beats 0..15 with matching side-band; in_inf_ready never drops.
- Backpressure: out_inf_ready=0, offer 1,2,3 -> 1 and 2 accepted, in_inf_ready=0, 3 held. Then set out_inf_ready=1 -> output order 1,2,3, and outputs are stable during the stall.
- Random: random in_inf_valid and out_inf_ready at 50% each for 10000 words -> scoreboard in-order match of {data, side}; no drops or duplicates.
- Chain of 4 stages with out_inf_ready=1 -> each word and its side-band appear together exactly 4 cycles after acceptance.
